// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control sequencer:
//   - major opcode values of the supported instruction classes
//   - FSM state encoding (also exported on the debug 'state' port)
//   - ALU operation selector encoding
//   - instruction-class enum and small per-class helper functions
// No ports (package).
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Sequencer states; the numeric values are visible on the debug port
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    // ALU operation selector driven to the datapath
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Instruction class latched in DECODE; CLS_NONE marks an unsupported opcode
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } instr_class_t;

    // ALU operation used by each class in EXECUTE
    function automatic logic [1:0] class_alu_op(input instr_class_t cls);
        logic [1:0] op;
        case (cls)
            CLS_R, CLS_I:        op = ALUOP_FUNCT;
            CLS_BRANCH:          op = ALUOP_CMP;
            default:             op = ALUOP_ADD;
        endcase
        return op;
    endfunction

    // Classes whose second ALU operand is the immediate rather than rs2
    function automatic logic class_uses_imm(input instr_class_t cls);
        return (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// ---------------------------------------------------------------------------
// instr_class_decode
// Purely combinational opcode classifier for the multi-cycle sequencer.
// Ports:
//   opcode  in   7  instr[6:0] from the instruction register
//   iclass  out  3  instruction class (CLS_NONE when unsupported)
//   legal   out  1  1 when the opcode belongs to a supported class
// ---------------------------------------------------------------------------
module instr_class_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t iclass,
    output logic         legal
);

    always_comb begin
        iclass = CLS_NONE;
        legal  = 1'b1;
        case (opcode)
            OP_R:      iclass = CLS_R;
            OP_I:      iclass = CLS_I;
            OP_LOAD:   iclass = CLS_LOAD;
            OP_STORE:  iclass = CLS_STORE;
            OP_BRANCH: iclass = CLS_BRANCH;
            default:   legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle sequencer for the RV32I datapath. Steps each instruction through
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK over a single shared memory
// port, drives the datapath strobes, handshakes with memory (mem_req /
// mem_ready) and traps on an unsupported opcode or a memory timeout.
// Parameters:
//   MEM_TIMEOUT  max wait cycles for mem_ready per access (0 = never time out)
//   CNT_W        width of retire_count
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode       in  7  instr[6:0], sampled in DECODE
//   branch_taken in  1  ALU compare result, used in EXECUTE
//   mem_ready    in  1  memory completes the current access this cycle
//   mem_req/mem_we/iord out  memory request, write qualifier, address select
//   ir_write/pc_write/pc_src/alu_src/alu_op/mem_to_reg/reg_write out
//                       datapath strobes
//   illegal/timeout out sticky trap causes
//   retire_count    out retired-instruction counter (wraps)
//   state           out current state, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retire_count,
    output logic [2:0]       state
);

    // The wait counter only has to reach MEM_TIMEOUT; with the timeout
    // disabled it never moves, so a single bit is enough.
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t             cur_state;
    state_t             next_state;
    instr_class_t       cls_q;
    instr_class_t       dec_class;
    logic               dec_legal;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_expired;
    logic               in_mem_access;
    logic               retire;
    logic               set_illegal;
    logic               set_timeout;

    instr_class_decode u_decode (
        .opcode (opcode),
        .iclass (dec_class),
        .legal  (dec_legal)
    );

    assign state         = cur_state;
    assign in_mem_access = (cur_state == ST_FETCH) || (cur_state == ST_MEMORY);

    // The counter holds the number of cycles already spent waiting, so the
    // access may still complete in the cycle where it equals the limit;
    // only a missing ready in that cycle traps.
    assign wait_expired = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        next_state  = cur_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src     = 1'b0;
        alu_op      = ALUOP_ADD;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        case (cur_state)
            ST_IDLE: begin
                next_state = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = ST_DECODE;
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    next_state  = ST_TRAP;
                end
            end

            ST_DECODE: begin
                if (dec_legal) begin
                    next_state = ST_EXECUTE;
                end else begin
                    set_illegal = 1'b1;
                    next_state  = ST_TRAP;
                end
            end

            ST_EXECUTE: begin
                alu_src = class_uses_imm(cls_q);
                alu_op  = class_alu_op(cls_q);
                case (cls_q)
                    CLS_R, CLS_I:         next_state = ST_WRITEBACK;
                    CLS_LOAD, CLS_STORE:  next_state = ST_MEMORY;
                    CLS_BRANCH: begin
                        pc_write   = branch_taken;
                        pc_src     = 1'b1;
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end
                    // Unreachable: DECODE never lets an unsupported class through
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = ST_TRAP;
                    end
                endcase
            end

            ST_MEMORY: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WRITEBACK;
                    end
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    next_state  = ST_TRAP;
                end
            end

            ST_WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
                retire     = 1'b1;
                next_state = ST_FETCH;
            end

            ST_TRAP: begin
                next_state = ST_TRAP;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // The class is captured once in DECODE so later states do not depend on
    // the IR opcode field staying stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q <= CLS_NONE;
        end else if (cur_state == ST_DECODE) begin
            cls_q <= dec_class;
        end
    end

    // Any state change clears the counter, which covers entry into FETCH and
    // MEMORY; outside those two states it simply stays at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (next_state != cur_state) begin
            wait_cnt <= '0;
        end else if (in_mem_access && !mem_ready && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            illegal <= illegal | set_illegal;
            timeout <= timeout | set_timeout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Self-checking bench for multicycle_ctrl_fsm. Each instruction is expanded
// into a list of expected cycles from the class rules (fetch, decode, execute,
// optional memory access, optional writeback, with wait cycles and traps),
// then driven one cycle at a time and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;
    import rv_ctrl_pkg::*;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic          branch_taken;
    logic          mem_ready;
    logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]    alu_op;
    logic          mem_to_reg, reg_write, illegal, timeout;
    logic [CW-1:0] retire_count;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    logic          exp_ill;
    logic          exp_to;
    logic [CW-1:0] exp_rc;

    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_BAD} kind_t;

    // One expected cycle: inputs to drive, outputs required, model updates
    typedef struct packed {
        logic       rdy;
        logic       bt;
        logic [6:0] op;
        logic [2:0] st;
        logic       req, we, io, irw, pcw, pcs, alus;
        logic [1:0] aluop;
        logic       m2r, rw;
        logic       retire, set_ill, set_to;
    } step_t;

    step_t plan[$];

    multicycle_ctrl_fsm #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .illegal      (illegal),
        .timeout      (timeout),
        .retire_count (retire_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic isLegal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic [6:0] opcodeOf(input kind_t k);
        logic [6:0] op;
        case (k)
            K_R:     op = OP_R;
            K_I:     op = OP_I;
            K_LD:    op = OP_LOAD;
            K_ST:    op = OP_STORE;
            K_BR:    op = OP_BRANCH;
            default: begin
                op = 7'($urandom);
                while (isLegal(op)) op = 7'($urandom);
            end
        endcase
        return op;
    endfunction

    // Inputs that must not matter in a cycle are randomized
    function automatic step_t blankStep(input logic [2:0] st);
        step_t s;
        s     = '0;
        s.st  = st;
        s.rdy = 1'($urandom);
        s.bt  = 1'($urandom);
        s.op  = 7'($urandom);
        return s;
    endfunction

    // Cycles of a memory access without ready; beyond TO waits the access
    // traps in the cycle after the TO-th wait.
    task automatic pushWaits(input logic [2:0] st, input logic io, input logic we,
                             input int waits, output bit trapped);
        step_t s;
        int    n;
        trapped = (waits > TO);
        n       = trapped ? TO + 1 : waits;
        for (int i = 0; i < n; i++) begin
            s     = blankStep(st);
            s.rdy = 1'b0;
            s.req = 1'b1;
            s.io  = io;
            s.we  = we;
            if (trapped && i == n - 1) s.set_to = 1'b1;
            plan.push_back(s);
        end
    endtask

    task automatic buildInstr(input kind_t k, input logic [6:0] op, input int fw,
                              input int mw, input logic bt);
        step_t s;
        bit    tr;
        pushWaits(3'd1, 1'b0, 1'b0, fw, tr);
        if (tr) return;
        s = blankStep(3'd1);
        s.rdy = 1'b1; s.req = 1'b1; s.irw = 1'b1; s.pcw = 1'b1;
        plan.push_back(s);

        s    = blankStep(3'd2);
        s.op = op;
        if (k == K_BAD) begin
            s.set_ill = 1'b1;
            plan.push_back(s);
            return;
        end
        plan.push_back(s);

        s       = blankStep(3'd3);
        s.alus  = (k == K_I) || (k == K_LD) || (k == K_ST);
        s.aluop = (k == K_R || k == K_I) ? 2'b10 : (k == K_BR) ? 2'b01 : 2'b00;
        if (k == K_BR) begin
            s.bt = bt; s.pcw = bt; s.pcs = 1'b1; s.retire = 1'b1;
            plan.push_back(s);
            return;
        end
        plan.push_back(s);

        if (k == K_LD || k == K_ST) begin
            pushWaits(3'd4, 1'b1, k == K_ST, mw, tr);
            if (tr) return;
            s = blankStep(3'd4);
            s.rdy = 1'b1; s.req = 1'b1; s.io = 1'b1; s.we = (k == K_ST);
            if (k == K_ST) begin
                s.retire = 1'b1;
                plan.push_back(s);
                return;
            end
            plan.push_back(s);
        end

        s = blankStep(3'd5);
        s.rw = 1'b1; s.m2r = (k == K_LD); s.retire = 1'b1;
        plan.push_back(s);
    endtask

    // Entered and left at posedge+1; outputs compared at the negedge
    task automatic applyStimulus(input step_t s);
        mem_ready    = s.rdy;
        branch_taken = s.bt;
        opcode       = s.op;
        @(negedge clk);
        checkOutput($sformatf("strobes_st%0d", s.st),
            {18'd0, state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
             alu_src, alu_op, mem_to_reg, reg_write},
            {18'd0, s.st, s.req, s.we, s.io, s.irw, s.pcw, s.pcs,
             s.alus, s.aluop, s.m2r, s.rw});
        checkOutput($sformatf("status_st%0d", s.st),
            32'({illegal, timeout, retire_count}), 32'({exp_ill, exp_to, exp_rc}));
        @(posedge clk);
        #1;
        if (s.retire)  exp_rc = exp_rc + 1'b1;
        if (s.set_ill) exp_ill = 1'b1;
        if (s.set_to)  exp_to = 1'b1;
    endtask

    task automatic runPlan();
        while (plan.size() > 0) applyStimulus(plan.pop_front());
    endtask

    task automatic runInstr(input kind_t k, input logic [6:0] op, input int fw,
                            input int mw, input logic bt);
        plan.delete();
        buildInstr(k, op, fw, mw, bt);
        runPlan();
    endtask

    task automatic trapCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(blankStep(3'd6));
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        exp_rc  = '0;
        checkOutput("rst_status", 32'({illegal, timeout, retire_count}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(blankStep(3'd0));
    endtask

    initial begin
        kind_t k;
        int    fw, mw;
        rst_n        = 1'b1;
        opcode       = '0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        exp_ill      = 1'b0;
        exp_to       = 1'b0;
        exp_rc       = '0;
        #2;
        doReset();

        $display("[TB] directed: R, LOAD with waits, STORE, BRANCH taken/not taken");
        runInstr(K_R, OP_R, 0, 0, 1'b0);
        runInstr(K_LD, OP_LOAD, 0, 3, 1'b0);
        runInstr(K_ST, OP_STORE, 1, 2, 1'b0);
        runInstr(K_BR, OP_BRANCH, 0, 0, 1'b1);
        runInstr(K_BR, OP_BRANCH, 0, 0, 1'b0);
        runInstr(K_I, OP_I, 2, 0, 1'b0);

        $display("[TB] directed: illegal opcode 7f");
        runInstr(K_BAD, 7'h7F, 0, 0, 1'b0);
        trapCycles(20);
        doReset();

        $display("[TB] directed: fetch timeout, ready on last allowed cycle, reset mid-wait");
        runInstr(K_R, OP_R, TO + 1, 0, 1'b0);
        trapCycles(3);
        doReset();
        runInstr(K_R, OP_R, TO, 0, 1'b0);
        runInstr(K_ST, OP_STORE, 0, TO + 1, 1'b0);
        trapCycles(3);
        doReset();
        plan.delete();
        buildInstr(K_R, OP_R, 3, 0, 1'b0);
        applyStimulus(plan.pop_front());
        applyStimulus(plan.pop_front());
        doReset();

        $display("[TB] directed: retire counter wrap");
        for (int i = 0; i < 20; i++) begin
            k = kind_t'($urandom_range(0, 4));
            runInstr(k, opcodeOf(k), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        $display("[TB] random instruction stream");
        for (int i = 0; i < 150; i++) begin
            k  = ($urandom_range(0, 19) == 0) ? K_BAD : kind_t'($urandom_range(0, 4));
            fw = ($urandom_range(0, 24) == 0) ? TO + 1 : $urandom_range(0, TO);
            mw = ($urandom_range(0, 24) == 0) ? TO + 1 : $urandom_range(0, TO);
            runInstr(k, opcodeOf(k), fw, mw, 1'($urandom));
            if (exp_ill || exp_to) begin
                trapCycles($urandom_range(1, 4));
                doReset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
